multicycle_ctrl: RTL and testbench

//  Multi-cycle control FSM for the RV32 teaching core; producer side of the ALU opcode interface.

---
 rtl/multicycle_ctrl_pkg.sv | 81 ++++++++
 rtl/multicycle_ctrl_if.sv | 42 ++++
 rtl/multicycle_ctrl_instr_decode.sv | 69 ++++++
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Purpose : shared types and constants for the RV32 multi-cycle controller and its ALU.
// Latency : n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   state_t        controller state encodings (FETCH is the reset state)
//   alu_op_t       5-bit ALUOp codes, also imported by the combinational ALU
//   instr_class_t  coarse instruction class produced by the decoder
//   dec_t          decoder result bundle
//   opcode/funct3/funct7 constants for the supported subset
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM_RD = 4'd5,
        S_MEM_WR = 4'd6,
        S_WB_ALU = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_TRAP   = 4'd10
    } state_t;

    // Fixed entry state; not meant to be overridden by the core.
    localparam state_t RESET_STATE = S_FETCH;

    // ALUOp codes. Note that SUB is the all-zero code, so a cleared bus reads as SUB.
    typedef enum logic [4:0] {
        ALU_SUB = 5'b00000,
        ALU_ADD = 5'b00001,
        ALU_SLL = 5'b00010,
        ALU_SRL = 5'b00011
    } alu_op_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_MEM = 3'd2,
        CLS_BR  = 3'd3,
        CLS_ILL = 3'd4
    } instr_class_t;

    typedef struct packed {
        instr_class_t cls;
        alu_op_t      alu_op_r;   // op for R-type (add/sub)
        alu_op_t      alu_op_i;   // op for OP-IMM (add/sll/srl)
        logic         is_lw;      // load (vs store) within CLS_MEM
        logic         is_bne;     // bne (vs beq) within CLS_BR
        logic         legal;
    } dec_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_SLL    = 3'b001;
    localparam logic [2:0] F3_SRL    = 3'b101;
    localparam logic [2:0] F3_WORD   = 3'b010;
    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU operation for an OP-IMM instruction, chosen by funct3 alone.
    // Legality (e.g. funct7 of shifts) is judged separately by the decoder.
    function automatic alu_op_t imm_alu_op(input logic [2:0] funct3);
        case (funct3)
            F3_SLL:  return ALU_SLL;
            F3_SRL:  return ALU_SRL;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Purpose : datapath/memory <-> controller signal bundle for the multi-cycle core.
// Latency : n/a (wires only).
// Backpressure: memory stalls the controller via mem_ready; controller holds its requests.
//
// Signals (direction as seen by the controller, modport master):
//   in : instr[31:0], alu_zero[7:0] (bit 0 used), mem_ready
//   out: mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
//        ALUOp[4:0], rf_we, wd_sel, illegal, state_dbg[3:0]
interface multicycle_ctrl_if;

    logic [31:0] instr;
    logic [7:0]  alu_zero;
    logic        mem_ready;

    logic        mem_re;
    logic        mem_we;
    logic        mem_addr_sel;
    logic        ir_we;
    logic        pc_we;
    logic        pc_src;
    logic        alu_src_b;
    logic [4:0]  ALUOp;
    logic        rf_we;
    logic        wd_sel;
    logic        illegal;
    logic [3:0]  state_dbg;

    // Controller side.
    modport master (
        input  instr, alu_zero, mem_ready,
        output mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
               ALUOp, rf_we, wd_sel, illegal, state_dbg
    );

    // Datapath / memory side.
    modport slave (
        output instr, alu_zero, mem_ready,
        input  mem_re, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_src_b,
               ALUOp, rf_we, wd_sel, illegal, state_dbg
    );

endinterface

// File: rtl/multicycle_ctrl_instr_decode.sv
// Purpose : classify the IR contents into the controller's instruction classes.
// Latency : combinational, 0 cycles.
// Backpressure: none; pure function of i_instr.
//
// Ports:
//   i_instr  in   32  current IR contents
//   o_dec    out  dec_t {cls, alu_op_r, alu_op_i, is_lw, is_bne, legal}
module instr_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output dec_t        o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_unused_fields;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Register indices and low immediate bits belong to the datapath.
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    always_comb begin
        // Sub-selectors are computed unconditionally; they only matter once
        // the class below says the instruction is of that kind.
        o_dec.cls      = CLS_ILL;
        o_dec.alu_op_r = w_funct7[5] ? ALU_SUB : ALU_ADD;
        o_dec.alu_op_i = imm_alu_op(w_funct3);
        o_dec.is_lw    = (w_opcode == OPC_LOAD);
        o_dec.is_bne   = (w_funct3 == F3_BNE);
        o_dec.legal    = 1'b0;

        case (w_opcode)
            OPC_OP: begin
                if (w_funct3 == F3_ADDSUB && (w_funct7 == F7_BASE || w_funct7 == F7_ALT))
                    o_dec.cls = CLS_R;
            end
            OPC_OP_IMM: begin
                case (w_funct3)
                    F3_ADDSUB: o_dec.cls = CLS_I;   // addi: funct7 is part of the immediate
                    F3_SLL,
                    F3_SRL: begin
                        // srai (funct7=0100000) is outside the supported subset.
                        if (w_funct7 == F7_BASE)
                            o_dec.cls = CLS_I;
                    end
                    default: ;
                endcase
            end
            OPC_LOAD,
            OPC_STORE: begin
                if (w_funct3 == F3_WORD)
                    o_dec.cls = CLS_MEM;
            end
            OPC_BRANCH: begin
                if (w_funct3 == F3_BEQ || w_funct3 == F3_BNE)
                    o_dec.cls = CLS_BR;
            end
            default: ;
        endcase

        o_dec.legal = (o_dec.cls != CLS_ILL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose : multi-cycle control FSM (fetch/decode/execute/memory/writeback) for the RV32 core.
// Latency : zero-wait memory: R/I-type 4 cycles, lw 5, sw 4, beq/bne 3.
// Backpressure: each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR holds the request one more cycle.
//
// Ports:
//   clk   in  1  rising-edge clock
//   rstn  in  1  asynchronous active-low reset; forces every output to 0 while low
//   bus   multicycle_ctrl_if.master  datapath/memory signals (see interface header)
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    multicycle_ctrl_if.master  bus
);

    state_t  r_state;
    state_t  w_state_nxt;
    logic    r_illegal;

    dec_t    w_dec;
    logic    w_taken;
    logic    w_unused_zero;

    logic    w_mem_re;
    logic    w_mem_we;
    logic    w_mem_addr_sel;
    logic    w_ir_we;
    logic    w_pc_we;
    logic    w_pc_src;
    logic    w_alu_src_b;
    alu_op_t w_alu_op;
    logic    w_rf_we;
    logic    w_wd_sel;

    instr_decode u_instr_decode (
        .i_instr (bus.instr),
        .o_dec   (w_dec)
    );

    // Only bit 0 of the ALU zero bus carries information.
    assign w_unused_zero = ^bus.alu_zero[7:1];

    // beq takes on zero, bne on non-zero.
    assign w_taken = w_dec.is_bne ^ bus.alu_zero[0];

    // ------------------------------------------------------------------
    // State register. illegal is set on entry to TRAP so it is visible in
    // the first TRAP cycle, and only reset clears it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= RESET_STATE;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == S_TRAP)
                r_illegal <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and Moore outputs. ir_we/pc_we in FETCH are additionally
    // qualified by mem_ready so the IR/PC only move on a completed fetch.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_re       = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_src       = 1'b0;
        w_alu_src_b    = 1'b0;
        w_alu_op       = ALU_ADD;
        w_rf_we        = 1'b0;
        w_wd_sel       = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_re       = 1'b1;
                w_mem_addr_sel = 1'b0;
                if (bus.mem_ready) begin
                    w_ir_we     = 1'b1;
                    w_pc_we     = 1'b1;   // PC+4 (pc_src=0)
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!w_dec.legal) begin
                    w_state_nxt = S_TRAP;
                end else begin
                    case (w_dec.cls)
                        CLS_R:   w_state_nxt = S_EXEC_R;
                        CLS_I:   w_state_nxt = S_EXEC_I;
                        CLS_MEM: w_state_nxt = S_ADDR;
                        CLS_BR:  w_state_nxt = S_BRANCH;
                        default: w_state_nxt = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R: begin
                w_alu_src_b = 1'b0;
                w_alu_op    = w_dec.alu_op_r;
                w_state_nxt = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_alu_src_b = 1'b1;
                w_alu_op    = w_dec.alu_op_i;
                w_state_nxt = S_WB_ALU;
            end
            S_ADDR: begin
                // rs1 + imm; the result lands in ALUOut for the memory address.
                w_alu_src_b = 1'b1;
                w_alu_op    = ALU_ADD;
                w_state_nxt = w_dec.is_lw ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_re       = 1'b1;
                w_mem_addr_sel = 1'b1;
                if (bus.mem_ready)
                    w_state_nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                w_mem_we       = 1'b1;
                w_mem_addr_sel = 1'b1;
                if (bus.mem_ready)
                    w_state_nxt = S_FETCH;
            end
            S_WB_ALU: begin
                w_rf_we     = 1'b1;
                w_wd_sel    = 1'b0;
                w_state_nxt = S_FETCH;
            end
            S_WB_MEM: begin
                w_rf_we     = 1'b1;
                w_wd_sel    = 1'b1;
                w_state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                // rs1 - rs2 drives alu_zero; the target was formed by the
                // datapath's old_pc+imm_b adder, so pc_src is set regardless.
                w_alu_src_b = 1'b0;
                w_alu_op    = ALU_SUB;
                w_pc_src    = 1'b1;
                w_pc_we     = w_taken;
                w_state_nxt = S_FETCH;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = RESET_STATE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs are forced low combinationally while rstn is asserted, so an
    // in-flight memory write or register/PC update is dropped immediately,
    // without waiting for a clock edge. ALUOp therefore reads 00000 in reset.
    // ------------------------------------------------------------------
    assign bus.mem_re       = rstn & w_mem_re;
    assign bus.mem_we       = rstn & w_mem_we;
    assign bus.mem_addr_sel = rstn & w_mem_addr_sel;
    assign bus.ir_we        = rstn & w_ir_we;
    assign bus.pc_we        = rstn & w_pc_we;
    assign bus.pc_src       = rstn & w_pc_src;
    assign bus.alu_src_b    = rstn & w_alu_src_b;
    assign bus.ALUOp        = rstn ? w_alu_op : 5'b00000;
    assign bus.rf_we        = rstn & w_rf_we;
    assign bus.wd_sel       = rstn & w_wd_sel;
    assign bus.illegal      = r_illegal;
    assign bus.state_dbg    = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Purpose : directed self-checking bench for multicycle_ctrl.
// Latency : n/a.
// Backpressure: mem_ready is driven per cycle from each scenario's table.
module tb_multicycle_ctrl;

    localparam logic [4:0] A = 5'b00001;  // add
    localparam logic [4:0] S = 5'b00000;  // sub
    localparam logic [4:0] L = 5'b00010;  // sll
    localparam logic [4:0] R = 5'b00011;  // srl

    localparam logic [31:0] ADD_I  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] SUB_I  = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] MUL_I  = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] ADDI_I = {12'hFFF, 5'd1, 3'b000, 5'd4, 7'b0010011};
    localparam logic [31:0] SLLI_I = {7'b0000000, 5'd3, 5'd1, 3'b001, 5'd4, 7'b0010011};
    localparam logic [31:0] SRLI_I = {7'b0000000, 5'd3, 5'd1, 3'b101, 5'd4, 7'b0010011};
    localparam logic [31:0] SRAI_I = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd4, 7'b0010011};
    localparam logic [31:0] LW_I   = {12'd8, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] SW_I   = {7'd0, 5'd5, 5'd1, 3'b010, 5'd4, 7'b0100011};
    localparam logic [31:0] BEQ_I  = {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'b1100011};
    localparam logic [31:0] BNE_I  = {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'b1100011};

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Frequently used expected vectors, filled at time 0.
    logic [18:0] f_go, f_idle, dec_v, addr_v, trap_v;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Expected output vector builder.
    function automatic logic [18:0] ev(input logic [3:0] st, input logic re, input logic we,
                                       input logic as, input logic irw, input logic pcw,
                                       input logic pcs, input logic asb, input logic [4:0] aop,
                                       input logic rfw, input logic wds, input logic ill);
        return {st, re, we, as, irw, pcw, pcs, asb, aop, rfw, wds, ill};
    endfunction

    // Same layout, read from the DUT.
    function automatic logic [18:0] obs();
        return {bus.state_dbg, bus.mem_re, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
                bus.pc_src, bus.alu_src_b, bus.ALUOp, bus.rf_we, bus.wd_sel, bus.illegal};
    endfunction

    // Per-cycle invariants.
    always @(negedge clk) begin
        #2;
        n_checks++;
        if ((bus.mem_re & bus.mem_we) !== 1'b0) begin
            n_fail++;
            $display("FAIL mem_excl t=%0t: mem_re=%b mem_we=%b, required not both 1",
                     $time, bus.mem_re, bus.mem_we);
        end
        n_checks++;
        if ((bus.ir_we & ~(bus.mem_ready & (bus.state_dbg == 4'd0))) !== 1'b0) begin
            n_fail++;
            $display("FAIL ir_we_qual t=%0t: ir_we=%b mem_ready=%b state=%0d, required ir_we only in FETCH with mem_ready",
                     $time, bus.ir_we, bus.mem_ready, bus.state_dbg);
        end
    end

    task automatic test_reset();
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs() !== 19'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got %h expected %h", obs(), 19'h0);
            end
        end
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs() !== f_idle) begin
            n_fail++;
            $display("FAIL reset_release_fetch: got %h expected %h", obs(), f_idle);
        end
        @(negedge clk);
    endtask

    task automatic test_add();
        logic [18:0] exp [5];
        logic        mr  [5];
        bus.instr = ADD_I;
        exp[0] = f_go;  mr[0] = 1'b1;
        exp[1] = dec_v; mr[1] = 1'b1;
        exp[2] = ev(4'd2, 0, 0, 0, 0, 0, 0, 0, A, 0, 0, 0); mr[2] = 1'b1;
        exp[3] = ev(4'd7, 0, 0, 0, 0, 0, 0, 0, A, 1, 0, 0); mr[3] = 1'b1;
        exp[4] = f_idle; mr[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = mr[i];
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL add cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sub();
        logic [18:0] exp [4];
        bus.instr = SUB_I;
        exp[0] = f_go;
        exp[1] = dec_v;
        exp[2] = ev(4'd2, 0, 0, 0, 0, 0, 0, 0, S, 0, 0, 0);
        exp[3] = ev(4'd7, 0, 0, 0, 0, 0, 0, 0, A, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL sub cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_imm();
        logic [31:0] ins [3];
        logic [4:0]  aop [3];
        logic [18:0] exp [4];
        ins[0] = ADDI_I; aop[0] = A;
        ins[1] = SLLI_I; aop[1] = L;
        ins[2] = SRLI_I; aop[2] = R;
        for (int k = 0; k < 3; k++) begin
            bus.instr = ins[k];
            exp[0] = f_go;
            exp[1] = dec_v;
            exp[2] = ev(4'd3, 0, 0, 0, 0, 0, 0, 1, aop[k], 0, 0, 0);
            exp[3] = ev(4'd7, 0, 0, 0, 0, 0, 0, 0, A, 1, 0, 0);
            for (int i = 0; i < 4; i++) begin
                bus.mem_ready = 1'b1;
                #1;
                n_checks++;
                if (obs() !== exp[i]) begin
                    n_fail++;
                    $display("FAIL imm%0d cyc%0d: got %h expected %h", k, i, obs(), exp[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [18:0] exp [8];
        logic        mr  [8];
        logic [18:0] mrd;
        bus.instr = LW_I;
        mrd = ev(4'd5, 1, 0, 1, 0, 0, 0, 0, A, 0, 0, 0);
        exp[0] = f_go;   mr[0] = 1'b1;
        exp[1] = dec_v;  mr[1] = 1'b1;
        exp[2] = addr_v; mr[2] = 1'b1;
        exp[3] = mrd;    mr[3] = 1'b0;
        exp[4] = mrd;    mr[4] = 1'b0;
        exp[5] = mrd;    mr[5] = 1'b1;
        exp[6] = ev(4'd8, 0, 0, 0, 0, 0, 0, 0, A, 1, 1, 0); mr[6] = 1'b1;
        exp[7] = f_idle; mr[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = mr[i];
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL lw_wait cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw();
        logic [18:0] exp [5];
        bus.instr = SW_I;
        exp[0] = f_go;
        exp[1] = dec_v;
        exp[2] = addr_v;
        exp[3] = ev(4'd6, 0, 1, 1, 0, 0, 0, 0, A, 0, 0, 0);
        exp[4] = f_idle;
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = (i < 4);
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL sw cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins [4];
        logic [7:0]  zr  [4];
        logic        tk  [4];
        logic [18:0] exp [3];
        ins[0] = BEQ_I; zr[0] = 8'h01; tk[0] = 1'b1;
        ins[1] = BNE_I; zr[1] = 8'h01; tk[1] = 1'b0;
        ins[2] = BEQ_I; zr[2] = 8'hFE; tk[2] = 1'b0;  // upper zero bits must be ignored
        ins[3] = BNE_I; zr[3] = 8'hFE; tk[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.instr    = ins[k];
            bus.alu_zero = zr[k];
            exp[0] = f_go;
            exp[1] = dec_v;
            exp[2] = ev(4'd9, 0, 0, 0, 0, tk[k], 1, 0, S, 0, 0, 0);
            for (int i = 0; i < 3; i++) begin
                bus.mem_ready = 1'b1;
                #1;
                n_checks++;
                if (obs() !== exp[i]) begin
                    n_fail++;
                    $display("FAIL branch%0d cyc%0d: got %h expected %h", k, i, obs(), exp[i]);
                end
                @(negedge clk);
            end
        end
        bus.alu_zero = 8'h00;
    endtask

    task automatic test_fetch_wait();
        logic [18:0] exp [6];
        logic        mr  [6];
        bus.instr    = BEQ_I;
        bus.alu_zero = 8'h00;  // not taken
        exp[0] = f_idle; mr[0] = 1'b0;
        exp[1] = f_idle; mr[1] = 1'b0;
        exp[2] = f_go;   mr[2] = 1'b1;
        exp[3] = dec_v;  mr[3] = 1'b0;
        exp[4] = ev(4'd9, 0, 0, 0, 0, 0, 1, 0, S, 0, 0, 0); mr[4] = 1'b0;
        exp[5] = f_idle; mr[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = mr[i];
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL fetch_wait cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_memwr();
        logic [18:0] exp [5];
        logic [18:0] mwr;
        bus.instr = SW_I;
        mwr = ev(4'd6, 0, 1, 1, 0, 0, 0, 0, A, 0, 0, 0);
        exp[0] = f_go;
        exp[1] = dec_v;
        exp[2] = addr_v;
        exp[3] = mwr;
        exp[4] = mwr;     // still waiting on memory
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = (i < 3);
            #1;
            n_checks++;
            if (obs() !== exp[i]) begin
                n_fail++;
                $display("FAIL rst_memwr cyc%0d: got %h expected %h", i, obs(), exp[i]);
            end
            if (i < 4) @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (bus.mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_memwr_drop: mem_we=%b expected 0", bus.mem_we);
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs() !== 19'h0) begin
            n_fail++;
            $display("FAIL rst_memwr_held: got %h expected %h", obs(), 19'h0);
        end
        rstn = 1'b1;
        #1;
        n_checks++;
        if (obs() !== f_idle) begin
            n_fail++;
            $display("FAIL rst_memwr_release: got %h expected %h", obs(), f_idle);
        end
        @(negedge clk);
    endtask

    task automatic test_trap_srai();
        bus.instr = SRAI_I;
        for (int i = 0; i < 14; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs() !== ((i == 0) ? f_go : (i == 1) ? dec_v : trap_v)) begin
                n_fail++;
                $display("FAIL trap_srai cyc%0d: got %h expected %h", i, obs(),
                         ((i == 0) ? f_go : (i == 1) ? dec_v : trap_v));
            end
            @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (bus.illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_clear: illegal=%b expected 0", bus.illegal);
        end
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_trap_other();
        bus.instr = MUL_I;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = 1'b1;
            #1;
            n_checks++;
            if (obs() !== ((i == 0) ? f_go : (i == 1) ? dec_v : trap_v)) begin
                n_fail++;
                $display("FAIL trap_mul cyc%0d: got %h expected %h", i, obs(),
                         ((i == 0) ? f_go : (i == 1) ? dec_v : trap_v));
            end
            @(negedge clk);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        bus.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs() !== f_idle) begin
            n_fail++;
            $display("FAIL trap_mul_recover: got %h expected %h", obs(), f_idle);
        end
        @(negedge clk);
    endtask

    initial begin
        f_go   = ev(4'd0, 1, 0, 0, 1, 1, 0, 0, A, 0, 0, 0);
        f_idle = ev(4'd0, 1, 0, 0, 0, 0, 0, 0, A, 0, 0, 0);
        dec_v  = ev(4'd1, 0, 0, 0, 0, 0, 0, 0, A, 0, 0, 0);
        addr_v = ev(4'd4, 0, 0, 0, 0, 0, 0, 1, A, 0, 0, 0);
        trap_v = ev(4'd10, 0, 0, 0, 0, 0, 0, 0, A, 0, 0, 1);

        bus.instr     = ADD_I;
        bus.alu_zero  = 8'h00;
        bus.mem_ready = 1'b0;
        rstn          = 1'b0;

        test_reset();
        test_add();
        test_sub();
        test_imm();
        test_lw_wait();
        test_sw();
        test_branch();
        test_fetch_wait();
        test_reset_mid_memwr();
        test_trap_srai();
        test_trap_other();

        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
